input_debounce_pair: RTL and testbench

Two-channel input conditioner sitting directly upstream of the half-adder stage. It takes the two raw pushbutton/switch operand inputs, synchronises each to `clk`, and debounces each one. It then presents clean, glitch-free operand levels that drive the adder's operand-a and operand-b inputs. It also emits a one-cycle strobe, with a per-channel mask, whenever either clean operand changes, so downstream logic can count or latch new results.

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_ch.sv | 48 ++++
 rtl/input_debounce_pair.sv | 44 ++++
 tb/tb_input_debounce_pair.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the two-channel operand debouncer.
package debounce_pkg;

  localparam int NUM_CH = 2;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;

  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, clean flop.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_MAX     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic clean,
  output logic flip
);

  localparam int CW = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Combinational flip event; the top registers it alongside clean.
  assign flip = ena && (sync != clean) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      clean  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (sync == clean) begin
        cnt <= '0;
      end else if (ena) begin
        if (cnt == LAST) begin
          clean <= ~clean;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_debounce_pair.sv
// Debounces the two raw operand inputs feeding the half-adder stage
// and strobes whenever either clean operand changes.
module input_debounce_pair
  import debounce_pkg::*;
#(
  parameter int CNT_MAX     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic              change_stb,
  output logic [NUM_CH-1:0] changed_mask
);

  logic [NUM_CH-1:0] flip;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_MAX     (CNT_MAX),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .raw   (raw_in[i]),
      .clean (clean_out[i]),
      .flip  (flip[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_stb   <= 1'b0;
      changed_mask <= '0;
    end else begin
      change_stb   <= |flip;
      changed_mask <= flip;
    end
  end

endmodule

// File: tb/tb_input_debounce_pair.sv
// Directed bench for input_debounce_pair with default parameters.
module tb_input_debounce_pair;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic       change_stb;
  logic [1:0] changed_mask;

  int checks;
  int failures;

  input_debounce_pair dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .raw_in       (raw_in),
    .clean_out    (clean_out),
    .change_stb   (change_stb),
    .changed_mask (changed_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [1:0] v);
    raw_in = v;
    for (int e = 0; e < 20; e++) tick();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 2'b00;
    #1;
    checks++;
    if ({clean_out, change_stb, changed_mask} !== 5'b0) begin
      failures++;
      $display("FAIL reset_init got=%b exp=00000",
               {clean_out, change_stb, changed_mask});
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) tick();
    checks++;
    if (clean_out !== 2'b00 || change_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle clean=%b stb=%b exp=00/0",
               clean_out, change_stb);
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] ec, em;
    raw_in = 2'b01;
    for (int e = 1; e <= 22; e++) begin
      tick();
      ec = (e >= 17) ? 2'b01 : 2'b00;
      em = (e == 17) ? 2'b01 : 2'b00;
      checks++;
      if (clean_out !== ec) begin
        failures++;
        $display("FAIL press_clean e=%0d got=%b exp=%b", e, clean_out, ec);
      end
      checks++;
      if (change_stb !== (e == 17) || changed_mask !== em) begin
        failures++;
        $display("FAIL press_stb e=%0d got=%b/%b exp=%b/%b",
                 e, change_stb, changed_mask, e == 17, em);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] ec, em;
    logic       es;
    raw_in = 2'b10;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) raw_in = 2'b00;
      checks++;
      if (clean_out !== 2'b00 || change_stb !== 1'b0) begin
        failures++;
        $display("FAIL glitch10 e=%0d got=%b/%b exp=00/0",
                 e, clean_out, change_stb);
      end
    end
    raw_in = 2'b10;
    for (int e = 1; e <= 36; e++) begin
      tick();
      if (e == 15) raw_in = 2'b00;
      ec = (e >= 17 && e < 32) ? 2'b10 : 2'b00;
      es = (e == 17 || e == 32);
      em = es ? 2'b10 : 2'b00;
      checks++;
      if (clean_out !== ec || change_stb !== es || changed_mask !== em) begin
        failures++;
        $display("FAIL glitch15 e=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, clean_out, change_stb, changed_mask, ec, es, em);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] ec, em;
    raw_in = 2'b11;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ec = (e >= 17) ? 2'b11 : 2'b00;
      em = (e == 17) ? 2'b11 : 2'b00;
      checks++;
      if (clean_out !== ec || change_stb !== (e == 17) || changed_mask !== em) begin
        failures++;
        $display("FAIL simul e=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, clean_out, change_stb, changed_mask, ec, e == 17, em);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] ec, em;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clean_out, change_stb, changed_mask} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=00000",
               {clean_out, change_stb, changed_mask});
    end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ec = (e >= 17) ? 2'b11 : 2'b00;
      em = (e == 17) ? 2'b11 : 2'b00;
      checks++;
      if (clean_out !== ec || change_stb !== (e == 17) || changed_mask !== em) begin
        failures++;
        $display("FAIL reset_relatch e=%0d got=%b/%b/%b exp=%b/%b/%b",
                 e, clean_out, change_stb, changed_mask, ec, e == 17, em);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [1:0] ec;
    raw_in = 2'b01;
    for (int e = 1; e <= 25; e++) begin
      tick();
      if (e == 5)  ena = 1'b0;
      if (e == 10) ena = 1'b1;
      ec = (e >= 22) ? 2'b01 : 2'b00;
      checks++;
      if (clean_out !== ec || change_stb !== (e == 22)) begin
        failures++;
        $display("FAIL ena_gate e=%0d got=%b/%b exp=%b/%b",
                 e, clean_out, change_stb, ec, e == 22);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [1:0] ec;
    raw_in = 2'b01;
    for (int e = 1; e <= 10; e++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ec = (e >= 17) ? 2'b01 : 2'b00;
      checks++;
      if (clean_out !== ec || change_stb !== (e == 17)) begin
        failures++;
        $display("FAIL reset_mid e=%0d got=%b/%b exp=%b/%b",
                 e, clean_out, change_stb, ec, e == 17);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_clean_press();
    settle(2'b00);
    test_glitch();
    settle(2'b00);
    test_simultaneous();
    test_async_reset();
    settle(2'b00);
    test_enable_gating();
    settle(2'b00);
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
